// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer that arms once pre-trigger history is full, counts post-trigger writes
// and reports the final sample address; outputs are registered from the next-state decode.
module capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DEC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic              trigger,
  output logic              trig_en,
  output logic              armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              set_capture_done,
  output logic [ADDR_W-1:0] trace_end,
  output logic              busy
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(1) << ADDR_W;
  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
  state_t            state, ns;
  logic [DEC_W-1:0]  dec_cnt, dec_nx;
  logic [ADDR_W:0]   smpl_cnt, smpl_nx;
  logic [ADDR_W-1:0] post_cnt, post_nx, waddr_nx, trace_nx;
  logic              cap_nx, armed_nx, we_nx;
  always_comb begin
    ns       = state;
    dec_nx   = dec_cnt;
    smpl_nx  = smpl_cnt;
    post_nx  = post_cnt;
    waddr_nx = waddr;
    trace_nx = trace_end;
    if (state == PRE || state == POST) begin
      dec_nx   = we ? '0 : dec_cnt + 1'b1;
      waddr_nx = we ? waddr + 1'b1 : waddr;
    end
    case (state)
      IDLE: if (start) begin
        ns       = PRE;
        dec_nx   = '0;
        smpl_nx  = '0;
        waddr_nx = '0;
      end
      PRE: begin
        smpl_nx = (we && smpl_cnt != FULL) ? smpl_cnt + 1'b1 : smpl_cnt;
        if (trigger && armed) begin
          ns       = (trig_pos == '0) ? DONE : POST;
          post_nx  = '0;
          trace_nx = (trig_pos != '0) ? trace_end : we ? waddr : waddr - 1'b1;
        end
      end
      POST: if (we) begin
        post_nx = post_cnt + 1'b1;
        if (post_cnt + 1'b1 == trig_pos) begin
          ns       = DONE;
          trace_nx = waddr;
        end
      end
      default: ns = IDLE;
    endcase
    // outputs are computed for the cycle being entered so they can be registered
    cap_nx   = ns == PRE || ns == POST;
    armed_nx = cap_nx && (armed || smpl_nx >= FULL - {1'b0, trig_pos});
    we_nx    = cap_nx && dec_nx == decimator;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      dec_cnt          <= '0;
      smpl_cnt         <= '0;
      post_cnt         <= '0;
      waddr            <= '0;
      trace_end        <= '0;
      trig_en          <= 1'b0;
      armed            <= 1'b0;
      we               <= 1'b0;
      set_capture_done <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= ns;
      dec_cnt          <= dec_nx;
      smpl_cnt         <= smpl_nx;
      post_cnt         <= post_nx;
      waddr            <= waddr_nx;
      trace_end        <= trace_nx;
      trig_en          <= cap_nx;
      armed            <= armed_nx;
      we               <= we_nx;
      set_capture_done <= ns == DONE;
      busy             <= ns != IDLE;
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed capture scenarios; expected write addresses and trace_end values are queued
// with the stimulus and checked by a monitor whenever the DUT writes or signals done.
module tb_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, trigger = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic [DW-1:0] decimator = '0;
  logic          trig_en, armed, we, set_capture_done, busy;
  logic [AW-1:0] waddr, trace_end;
  int            errors = 0, checks = 0;
  int            wq[$];
  int            dq[$];

  capture_ctrl #(.ADDR_W(AW), .DEC_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trig_pos(trig_pos), .decimator(decimator),
    .trigger(trigger), .trig_en(trig_en), .armed(armed), .we(we), .waddr(waddr),
    .set_capture_done(set_capture_done), .trace_end(trace_end), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input int n);
    for (int k = 0; k < n; k++) wq.push_back(k % (1 << AW));
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!set_capture_done && n < lim) begin
      step;
      n++;
    end
    chk("done_seen", set_capture_done, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (wq.size() == 0) chk("we_unexpected", we, 1'b0);
      else chk("waddr", waddr, wq.pop_front());
    end
    if (rst_n && set_capture_done) begin
      if (dq.size() == 0) chk("done_unexpected", set_capture_done, 1'b0);
      else chk("trace_end", trace_end, dq.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step;
    chk("rst_outs", {trig_en, armed, we, set_capture_done, busy}, 5'b0);
    chk("rst_waddr", waddr, 0);
    chk("rst_trace", trace_end, 0);
    rst_n = 1'b1;
    step;
    // capture 1: decimator 0, trig_pos 4
    decimator = 0; trig_pos = 4; start = 1'b1;
    push_addrs(24); dq.push_back(7);
    step; start = 1'b0;
    chk("t1_trig_en", trig_en, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_we_c1", we, 1'b1);
    repeat (11) step;
    chk("t1_armed_c12", armed, 1'b0);
    step;
    chk("t1_armed_c13", armed, 1'b1);
    repeat (7) step;
    trigger = 1'b1;
    repeat (5) step;
    chk("t1_done", set_capture_done, 1'b1);
    chk("t1_done_we", we, 1'b0);
    chk("t1_done_trig_en", trig_en, 1'b0);
    chk("t1_done_busy", busy, 1'b1);
    step; trigger = 1'b0;
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_wq_empty", wq.size(), 0);
    // capture 2: decimator 3, trig_pos 15, wraps, start ignored while busy and in DONE
    decimator = 3; trig_pos = 15; start = 1'b1;
    push_addrs(34); dq.push_back(1);
    step; start = 1'b0;
    repeat (2) step;
    chk("t2_we_c3", we, 1'b0);
    step;
    chk("t2_we_c4", we, 1'b1);
    chk("t2_armed_c4", armed, 1'b0);
    step;
    chk("t2_we_c5", we, 1'b0);
    chk("t2_armed_c5", armed, 1'b1);
    repeat (25) step;
    start = 1'b1;
    step; start = 1'b0;
    repeat (46) step;
    trigger = 1'b1;
    repeat (23) step;
    start = 1'b1;
    step; start = 1'b0;
    wait_done(100);
    trigger = 1'b0; start = 1'b1;
    step; start = 1'b0;
    chk("t2_no_restart", busy, 1'b0);
    repeat (3) step;
    chk("t2_idle_busy", busy, 1'b0);
    chk("t2_idle_we", we, 1'b0);
    chk("t2_wq_empty", wq.size(), 0);
    // capture 3: trig_pos 0, trigger held from the start
    decimator = 1; trig_pos = 0; start = 1'b1; trigger = 1'b1;
    push_addrs(16); dq.push_back(15);
    step; start = 1'b0;
    repeat (31) step;
    chk("t3_armed_c32", armed, 1'b0);
    chk("t3_we_c32", we, 1'b1);
    step;
    chk("t3_armed_c33", armed, 1'b1);
    step;
    chk("t3_done", set_capture_done, 1'b1);
    chk("t3_trace", trace_end, 15);
    trigger = 1'b0;
    step;
    chk("t3_busy_low", busy, 1'b0);
    chk("t3_wq_empty", wq.size(), 0);
    // capture 4: reset in POST aborts, then a clean capture
    decimator = 0; trig_pos = 8; start = 1'b1;
    push_addrs(11);
    step; start = 1'b0;
    repeat (8) step;
    chk("t4_armed_c9", armed, 1'b1);
    step; trigger = 1'b1;
    repeat (2) step;
    rst_n = 1'b0;
    step;
    chk("t4_rst_outs", {trig_en, armed, we, set_capture_done, busy}, 5'b0);
    chk("t4_rst_waddr", waddr, 0);
    chk("t4_rst_trace", trace_end, 0);
    rst_n = 1'b1; trigger = 1'b0;
    step;
    chk("t4_wq_empty", wq.size(), 0);
    trig_pos = 2; start = 1'b1;
    push_addrs(16); wq.push_back(0); wq.push_back(1); dq.push_back(1);
    step; start = 1'b0;
    repeat (15) step;
    trigger = 1'b1;
    wait_done(20);
    trigger = 1'b0;
    step;
    chk("t5_busy_low", busy, 1'b0);
    chk("t5_wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sample-capture sequencer for the scope datapath. Sits directly downstream of the trigger latch: it drives that latch's armed, trig_en and set_capture_done inputs and consumes the latched trigger.
- Generates decimated write strobes and circular addresses for the sample RAM.
- Arms only once enough pre-trigger history is stored, counts post-trigger samples, then reports the final write address.

Parameters:
- ADDR_W, 9: sample RAM address width; DEPTH = 2^ADDR_W entries.
- DEC_W, 4: width of the decimation control.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset; synchronous, active-low.
- start, input, 1: capture command; single-cycle pulse.
- trig_pos, input, ADDR_W: number of samples to store after the trigger.
- decimator, input, DEC_W: store one sample every decimator+1 clocks.
- trigger, input, 1: latched trigger; stays high until set_capture_done.
- trig_en, output, 1: high while a capture is in progress.
- armed, output, 1: pre-trigger history is full.
- we, output, 1: sample RAM write enable.
- waddr, output, ADDR_W: sample RAM write address.
- set_capture_done, output, 1: one-cycle pulse at the end of a capture.
- trace_end, output, ADDR_W: address of the last stored sample of the completed capture.
- busy, output, 1: not in IDLE.

Behaviour:
- Reset (rst_n low at posedge clk):
  - State goes to IDLE.
  - trig_en, armed, we, set_capture_done and busy go to 0.
  - waddr and trace_end go to 0.
  - All internal counters clear.
  - Reset asserted mid-capture aborts the capture: no done pulse, and trace_end keeps its reset value 0.
- States: IDLE, PRE, POST, DONE. All outputs are registered.
- IDLE:
  - start=1 -> PRE next cycle; waddr<=0, dec_cnt<=0, smpl_cnt<=0.
  - Otherwise stay in IDLE.
- Decimation (PRE and POST):
  - dec_cnt counts 0..decimator.
  - On the cycle dec_cnt==decimator: we=1, dec_cnt<=0, and waddr advances by 1 the next cycle, wrapping DEPTH-1 -> 0.
  - Otherwise we=0.
  - decimator=0 gives a write every clock.
  - decimator is sampled live; a change mid-capture takes effect at the next dec_cnt compare.
- smpl_cnt:
  - ADDR_W+1 bits.
  - Increments on each write in PRE and saturates at DEPTH.
- armed:
  - Registered as (smpl_cnt >= DEPTH - trig_pos), evaluated only in PRE/POST.
  - Once set, it stays high until DONE.
  - Example: trig_pos=0 arms after DEPTH writes; trig_pos=DEPTH-1 arms after 1 write.
- trig_en: high in PRE and POST.
- busy: high in PRE, POST and DONE.
- PRE -> POST:
  - Occurs on a cycle with trigger=1 and armed=1; post_cnt<=0.
  - A write on that same cycle counts as pre-trigger.
  - trigger=1 while armed=0 is ignored. The upstream latch cannot set in that case, so this only arises from bench misuse.
- POST:
  - Each write increments post_cnt.
  - The write that makes post_cnt==trig_pos -> DONE next cycle, with trace_end<=that write's address.
- trig_pos==0:
  - PRE -> DONE directly on trigger; no post-trigger samples are written.
  - trace_end <= waddr-1 (mod DEPTH), the last address actually written.
  - If a write occurs on that same cycle, trace_end <= that write's address instead.
- DONE:
  - Lasts exactly one cycle: set_capture_done=1, we=0, trig_en=0, armed<=0; then -> IDLE.
- start while busy: ignored.
- start on the same cycle as DONE: ignored; it must arrive in IDLE.
- Latency:
  - start -> trig_en high: 1 cycle.
  - Final post-trigger write -> set_capture_done: 1 cycle.
  - set_capture_done -> busy low: 1 cycle.

Test Plan:
- ADDR_W=4, decimator=0, trig_pos=4, start at cycle 0 -> we every cycle from cycle 1; armed rises after the 12th write; trigger held high from cycle 20 -> exactly 4 further writes, set_capture_done one cycle later, trace_end = address of the 4th post-trigger write, busy low the cycle after.
- decimator=3 -> we asserted every 4th clock; waddr increments 0,1,2,... and wraps from 15 to 0.
- trig_pos=0, trigger held high from cycle 0 -> armed only after 16 writes; PRE->DONE on the first armed cycle; trace_end=15; no post-trigger writes.
- trig_pos=15 -> armed after the 1st write; 15 post-trigger writes; trace_end correct across wrap.
- rst_n low mid-POST -> next cycle all outputs 0, state IDLE, no set_capture_done pulse; a subsequent start runs a clean capture.
- start pulsed during PRE/POST and in the DONE cycle -> ignored: waddr not reset, exactly one done pulse, no restart.
